// File: rtl/rob_pkg.sv
// Shared widths, entry layout and payload types for the 8-entry reorder buffer.
package rob_pkg;

    localparam int unsigned NUM_ENTRIES     = 8;
    localparam int unsigned LOG_NUM_ENTRIES = 3;
    localparam int unsigned CNT_W           = LOG_NUM_ENTRIES + 1;
    localparam int unsigned WIDTH           = 41;

    // Entry bit positions: [40] done, [39] exc, [38:34] dest, [33:32] type, [31:0] value
    localparam int unsigned DONE_BIT  = 40;
    localparam int unsigned EXC_BIT   = 39;
    localparam int unsigned DEST_MSB  = 38;
    localparam int unsigned DEST_LSB  = 34;
    localparam int unsigned TYPE_MSB  = 33;
    localparam int unsigned TYPE_LSB  = 32;
    localparam int unsigned VALUE_MSB = 31;
    localparam int unsigned VALUE_LSB = 0;

    localparam int unsigned DEST_W  = DEST_MSB - DEST_LSB + 1;
    localparam int unsigned TYPE_W  = TYPE_MSB - TYPE_LSB + 1;
    localparam int unsigned VALUE_W = VALUE_MSB - VALUE_LSB + 1;

    typedef struct packed {
        logic               done;
        logic               exc;
        logic [DEST_W-1:0]  dest;
        logic [TYPE_W-1:0]  typ;
        logic [VALUE_W-1:0] value;
    } rob_entry_t;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [TYPE_W-1:0] typ;
    } rob_meta_t;

endpackage

// File: rtl/rob_ptr_counter.sv
// Wrapping ring pointer with enable and synchronous clear (used for head and tail).
module rob_ptr_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/rob_controller.sv
// Reorder buffer allocation / writeback / in-order commit control.
// Optional ROB_STATS_EN adds commit and full-stall saturating counters.
module rob_controller
    import rob_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    input  logic [DEST_W-1:0]          alloc_dest,
    input  logic [TYPE_W-1:0]          alloc_type,
    output logic                       alloc_ready,
    output logic [LOG_NUM_ENTRIES-1:0] alloc_tag,
    input  logic                       wb_valid,
    input  logic [LOG_NUM_ENTRIES-1:0] wb_tag,
    input  logic [VALUE_W-1:0]         wb_value,
    input  logic                       wb_exc,
    output logic                       commit_valid,
    input  logic                       commit_ready,
    output logic [LOG_NUM_ENTRIES-1:0] commit_tag,
    output logic [DEST_W-1:0]          commit_dest,
    output logic [VALUE_W-1:0]         commit_value,
    output logic                       commit_exc,
    output logic                       flush,
    output logic [LOG_NUM_ENTRIES-1:0] rf_wr_addr_a,
    output logic [WIDTH-1:0]           rf_wr_data_a,
    output logic                       rf_we_a,
    output logic [LOG_NUM_ENTRIES-1:0] rf_wr_addr_b,
    output logic [WIDTH-1:0]           rf_wr_data_b,
    output logic                       rf_we_b,
    output logic [LOG_NUM_ENTRIES-1:0] rf_rd_addr_c,
    input  logic [WIDTH-1:0]           rf_rd_data_c
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]                stat_commits,
    output logic [31:0]                stat_full_stalls
`endif
);

    logic [LOG_NUM_ENTRIES-1:0] head;
    logic [LOG_NUM_ENTRIES-1:0] tail;
    logic [CNT_W-1:0]           count;
    rob_meta_t                  meta [NUM_ENTRIES];

    logic                       alloc_fire;
    logic                       wb_fire;
    logic                       commit_fire;
    logic                       exc_commit;
    logic [LOG_NUM_ENTRIES-1:0] wb_offset;
    logic                       wb_in_flight;
    rob_entry_t                 alloc_entry;
    rob_entry_t                 wb_entry;
    logic                       unused_head_type;

    rob_ptr_counter #(.W(LOG_NUM_ENTRIES)) u_head (
        .clk   (clk),
        .reset (reset),
        .en    (commit_fire),
        .clr   (exc_commit),
        .ptr   (head)
    );

    rob_ptr_counter #(.W(LOG_NUM_ENTRIES)) u_tail (
        .clk   (clk),
        .reset (reset),
        .en    (alloc_fire),
        .clr   (exc_commit),
        .ptr   (tail)
    );

    // Head entry is read straight through port c; commit outputs are combinational.
    assign rf_rd_addr_c     = head;
    assign commit_tag       = head;
    assign commit_dest      = rf_rd_data_c[DEST_MSB:DEST_LSB];
    assign commit_value     = rf_rd_data_c[VALUE_MSB:VALUE_LSB];
    assign commit_exc       = rf_rd_data_c[EXC_BIT];
    assign unused_head_type = ^rf_rd_data_c[TYPE_MSB:TYPE_LSB];

    assign commit_valid = (count != '0) && rf_rd_data_c[DONE_BIT];
    assign commit_fire  = commit_valid && commit_ready;
    assign exc_commit   = commit_fire && commit_exc;

    assign alloc_ready = (count != CNT_W'(NUM_ENTRIES));
    assign alloc_tag   = tail;

    // A tag is in flight when its distance from head is below the occupancy.
    assign wb_offset    = wb_tag - head;
    assign wb_in_flight = ({1'b0, wb_offset} < count);

    // An exception commit squashes everything else presented in the same cycle.
    assign alloc_fire = alloc_valid && alloc_ready && !exc_commit && !reset;
    assign wb_fire    = wb_valid && wb_in_flight && !exc_commit && !reset;

    always_comb begin
        alloc_entry      = '0;
        alloc_entry.dest = alloc_dest;
        alloc_entry.typ  = alloc_type;

        wb_entry       = '0;
        wb_entry.done  = 1'b1;
        wb_entry.exc   = wb_exc;
        wb_entry.dest  = meta[wb_tag].dest;
        wb_entry.typ   = meta[wb_tag].typ;
        wb_entry.value = wb_value;

        rf_we_a      = alloc_fire;
        rf_wr_addr_a = tail;
        rf_wr_data_a = alloc_entry;
        rf_we_b      = wb_fire;
        rf_wr_addr_b = wb_tag;
        rf_wr_data_b = wb_entry;
    end

    // Local copy of dest/type so writeback can rebuild the full entry without a read.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            meta[tail] <= '{dest: alloc_dest, typ: alloc_type};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            flush <= 1'b0;
        end else begin
            flush <= exc_commit;
            if (exc_commit) begin
                count <= '0;
            end else if (alloc_fire && !commit_fire) begin
                count <= count + CNT_W'(1);
            end else if (commit_fire && !alloc_fire) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef ROB_STATS_EN
    // Saturating event counters for performance monitoring.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_commits     <= '0;
            stat_full_stalls <= '0;
        end else begin
            if (commit_fire && (stat_commits != '1)) begin
                stat_commits <= stat_commits + 32'(1);
            end
            if (alloc_valid && !alloc_ready && (stat_full_stalls != '1)) begin
                stat_full_stalls <= stat_full_stalls + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_controller.sv
// Scoreboard bench for rob_controller with a behavioural register file on ports a/b/c.
module tb_rob_controller;
    import rob_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [4:0]  alloc_dest;
    logic [1:0]  alloc_type;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_value;
    logic        wb_exc;
    logic        commit_valid;
    logic        commit_ready;
    logic [2:0]  commit_tag;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value;
    logic        commit_exc;
    logic        flush;
    logic [2:0]  rf_wr_addr_a;
    logic [40:0] rf_wr_data_a;
    logic        rf_we_a;
    logic [2:0]  rf_wr_addr_b;
    logic [40:0] rf_wr_data_b;
    logic        rf_we_b;
    logic [2:0]  rf_rd_addr_c;
    logic [40:0] rf_rd_data_c;
`ifdef ROB_STATS_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_full_stalls;
`endif

    always #5 clk = ~clk;

    rob_controller dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_dest   (alloc_dest),
        .alloc_type   (alloc_type),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_value     (wb_value),
        .wb_exc       (wb_exc),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_tag   (commit_tag),
        .commit_dest  (commit_dest),
        .commit_value (commit_value),
        .commit_exc   (commit_exc),
        .flush        (flush),
        .rf_wr_addr_a (rf_wr_addr_a),
        .rf_wr_data_a (rf_wr_data_a),
        .rf_we_a      (rf_we_a),
        .rf_wr_addr_b (rf_wr_addr_b),
        .rf_wr_data_b (rf_wr_data_b),
        .rf_we_b      (rf_we_b),
        .rf_rd_addr_c (rf_rd_addr_c),
        .rf_rd_data_c (rf_rd_data_c)
`ifdef ROB_STATS_EN
        ,
        .stat_commits     (stat_commits),
        .stat_full_stalls (stat_full_stalls)
`endif
    );

    // Behavioural register file: two write ports, one asynchronous read port.
    logic [40:0] mem [8];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            if (rf_we_a) mem[rf_wr_addr_a] <= rf_wr_data_a;
            if (rf_we_b) mem[rf_wr_addr_b] <= rf_wr_data_b;
        end
    end
    assign rf_rd_data_c = mem[rf_rd_addr_c];

    typedef struct packed {
        logic [2:0] tag;
        logic [4:0] dest;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [4:0]  m_dest [8];
    logic [1:0]  m_typ  [8];
    logic [31:0] m_val  [8];
    logic        m_exc  [8];
    logic [2:0]  exp_tail;
    logic [2:0]  wrap_tag [20];
    int          total = 0;
    int          bad = 0;
    int          n_commits = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every commit handshake is checked against the in-order scoreboard.
    always @(negedge clk) begin
        if (!reset && commit_valid && commit_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL commit_unexpected: got tag %0d expected no commit", commit_tag);
            end else begin
                mon_e = sbq.pop_front();
                chk("commit_tag",   64'(commit_tag),   64'(mon_e.tag));
                chk("commit_dest",  64'(commit_dest),  64'(mon_e.dest));
                chk("commit_value", 64'(commit_value), 64'(m_val[mon_e.tag]));
                chk("commit_exc",   64'(commit_exc),   64'(m_exc[mon_e.tag]));
            end
            n_commits++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input logic [4:0] d, input logic [1:0] t,
                         input bit wv, input logic [2:0] wt, input logic [31:0] wval,
                         input bit wexc, input bit cr);
        alloc_valid  = av;
        alloc_dest   = d;
        alloc_type   = t;
        wb_valid     = wv;
        wb_tag       = wt;
        wb_value     = wval;
        wb_exc       = wexc;
        commit_ready = cr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic exp_alloc(input bit accept);
        if (accept) begin
            chk("alloc_tag",    64'(alloc_tag),    64'(exp_tail));
            chk("rf_we_a",      64'(rf_we_a),      64'(1));
            chk("rf_wr_addr_a", 64'(rf_wr_addr_a), 64'(exp_tail));
            chk("rf_wr_data_a", 64'(rf_wr_data_a), 64'({2'b00, alloc_dest, alloc_type, 32'h0}));
            m_dest[exp_tail] = alloc_dest;
            m_typ[exp_tail]  = alloc_type;
            sbq.push_back(exp_t'{tag: exp_tail, dest: alloc_dest});
            exp_tail = exp_tail + 3'd1;
        end else begin
            chk("rf_we_a_blocked", 64'(rf_we_a), 64'(0));
        end
    endtask

    task automatic exp_wb(input bit accept);
        if (accept) begin
            chk("rf_we_b",      64'(rf_we_b),      64'(1));
            chk("rf_wr_addr_b", 64'(rf_wr_addr_b), 64'(wb_tag));
            chk("rf_wr_data_b", 64'(rf_wr_data_b),
                64'({1'b1, wb_exc, m_dest[wb_tag], m_typ[wb_tag], wb_value}));
            m_val[wb_tag] = wb_value;
            m_exc[wb_tag] = wb_exc;
        end else begin
            chk("rf_we_b_blocked", 64'(rf_we_b), 64'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_val[i] = '0;
            m_exc[i] = 1'b0;
            m_dest[i] = '0;
            m_typ[i] = '0;
        end
        reset   = 1'b1;
        mem_clr = 1'b1;
        idle();
        tick();
        mem_clr = 1'b0;
        // Requests during reset must not reach the register file.
        drive(1'b1, 5'd4, 2'd1, 1'b1, 3'd0, 32'h1, 1'b0, 1'b0);
        chk("reset_we_a", 64'(rf_we_a), 64'(0));
        chk("reset_we_b", 64'(rf_we_b), 64'(0));
        tick();
        reset = 1'b0;
        idle();
        chk("reset_alloc_ready",  64'(alloc_ready),  64'(1));
        chk("reset_alloc_tag",    64'(alloc_tag),    64'(0));
        chk("reset_commit_valid", 64'(commit_valid), 64'(0));
        chk("reset_flush",        64'(flush),        64'(0));
        chk("reset_count",        64'(dut.count),    64'(0));
        exp_tail = 3'd0;

        // Three allocations, out-of-order writeback, in-order commit.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 1), 2'(i), 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
            exp_alloc(1'b1);
            tick();
        end
        idle();
        chk("p1_count",        64'(dut.count),    64'(3));
        chk("p1_commit_valid", 64'(commit_valid), 64'(0));
        drive(1'b0, 5'd0, 2'd0, 1'b1, 3'd1, 32'hAA, 1'b0, 1'b1);
        exp_wb(1'b1);
        chk("p1_wait_head", 64'(commit_valid), 64'(0));
        tick();
        drive(1'b0, 5'd0, 2'd0, 1'b1, 3'd0, 32'h55, 1'b0, 1'b1);
        exp_wb(1'b1);
        chk("p1_wb_latency", 64'(commit_valid), 64'(0));
        tick();
        drive(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        chk("p1_commit0_valid", 64'(commit_valid), 64'(1));
        tick();
        drive(1'b0, 5'd0, 2'd0, 1'b1, 3'd2, 32'h77, 1'b0, 1'b1);
        chk("p1_commit1_valid", 64'(commit_valid), 64'(1));
        exp_wb(1'b1);
        tick();
        drive(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        chk("p1_head_after2", 64'(dut.head), 64'(2));
        chk("p1_commit2_valid", 64'(commit_valid), 64'(1));
        tick();
        idle();
        chk("p1_empty_count", 64'(dut.count), 64'(0));
        chk("p1_commits",     64'(n_commits), 64'(3));

        // Fill to 8 with no commit, try a 9th, then same-cycle alloc+commit at 7.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(8 + i), 2'(i), 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
            chk("full_ready_before", 64'(alloc_ready), 64'(1));
            exp_alloc(1'b1);
            tick();
        end
        drive(1'b1, 5'd31, 2'd3, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        chk("full_alloc_ready", 64'(alloc_ready), 64'(0));
        chk("full_count",       64'(dut.count),   64'(8));
        exp_alloc(1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 5'd0, 2'd0, 1'b1, 3'(3 + i), 32'h100 + 32'(i), 1'b0, 1'b0);
            exp_wb(1'b1);
            tick();
        end
        drive(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        chk("full_commit_valid", 64'(commit_valid), 64'(1));
        tick();
        idle();
        chk("count_7", 64'(dut.count), 64'(7));
        drive(1'b1, 5'd20, 2'd1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        chk("both_commit_valid", 64'(commit_valid), 64'(1));
        exp_alloc(1'b1);
        tick();
        idle();
        chk("both_count_7", 64'(dut.count), 64'(7));
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
            chk("drain_valid", 64'(commit_valid), 64'(1));
            tick();
        end
        drive(1'b0, 5'd0, 2'd0, 1'b1, 3'd3, 32'h333, 1'b0, 1'b1);
        chk("realloc_not_done", 64'(commit_valid), 64'(0));
        exp_wb(1'b1);
        tick();
        drive(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        chk("realloc_done", 64'(commit_valid), 64'(1));
        tick();
        idle();
        chk("empty_count",       64'(dut.count),    64'(0));
        chk("empty_stale_valid", 64'(commit_valid), 64'(0));
        chk("full_commits",      64'(n_commits),    64'(12));

        // 20 entries streamed through alloc -> writeback -> commit, wrapping tags.
        for (int i = 0; i < 22; i++) begin
            automatic bit av = (i < 20);
            automatic bit wv = (i >= 1) && (i <= 20);
            automatic logic [2:0] wt = wv ? wrap_tag[i - 1] : 3'd0;
            drive(av, 5'(i), 2'(i), wv, wt, 32'h1000 + 32'(i - 1), 1'b0, 1'b1);
            if (av) begin
                wrap_tag[i] = exp_tail;
                exp_alloc(1'b1);
            end
            if (wv) exp_wb(1'b1);
            tick();
        end
        idle();
        chk("wrap_count",     64'(dut.count), 64'(0));
        chk("wrap_alloc_tag", 64'(alloc_tag), 64'(0));
        chk("wrap_commits",   64'(n_commits), 64'(32));

        // Writebacks to tags outside the in-flight window are dropped.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'(5 + i), 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
            exp_alloc(1'b1);
            tick();
        end
        drive(1'b0, 5'd0, 2'd0, 1'b1, 3'd5, 32'hDEAD, 1'b0, 1'b0);
        exp_wb(1'b0);
        tick();
        drive(1'b0, 5'd0, 2'd0, 1'b1, 3'd2, 32'hBEEF, 1'b0, 1'b0);
        exp_wb(1'b0);
        tick();
        idle();
        chk("ign_count",        64'(dut.count),    64'(2));
        chk("ign_commit_valid", 64'(commit_valid), 64'(0));
        chk("ign_alloc_tag",    64'(alloc_tag),    64'(2));
        chk("ign_commit_tag",   64'(commit_tag),   64'(0));

        // Exception commit with tags 1-3 still in flight and a concurrent alloc/writeback.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'(7 + i), 2'd2, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
            exp_alloc(1'b1);
            tick();
        end
        drive(1'b0, 5'd0, 2'd0, 1'b1, 3'd0, 32'hE0, 1'b1, 1'b0);
        exp_wb(1'b1);
        tick();
        drive(1'b1, 5'd9, 2'd1, 1'b1, 3'd2, 32'h22, 1'b0, 1'b1);
        chk("exc_commit_valid", 64'(commit_valid), 64'(1));
        chk("exc_commit_exc",   64'(commit_exc),   64'(1));
        exp_alloc(1'b0);
        exp_wb(1'b0);
        tick();
        sbq.delete();
        exp_tail = 3'd0;
        idle();
        chk("flush_pulse",      64'(flush),        64'(1));
        chk("flush_count",      64'(dut.count),    64'(0));
        chk("flush_head",       64'(commit_tag),   64'(0));
        chk("flush_tail",       64'(alloc_tag),    64'(0));
        chk("flush_no_commit",  64'(commit_valid), 64'(0));
        chk("flush_alloc_rdy",  64'(alloc_ready),  64'(1));
        tick();
        idle();
        chk("flush_one_cycle",  64'(flush),        64'(0));
        chk("exc_commits",      64'(n_commits),    64'(33));

        // Normal operation resumes from tag 0 after a flush.
        drive(1'b1, 5'd10, 2'd2, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        exp_alloc(1'b1);
        tick();
        drive(1'b0, 5'd0, 2'd0, 1'b1, 3'd0, 32'h5A, 1'b0, 1'b0);
        exp_wb(1'b1);
        tick();
        drive(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        chk("post_flush_valid", 64'(commit_valid), 64'(1));
        tick();

        // Reset in the middle of traffic overrides everything.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'(12 + i), 2'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
            exp_alloc(1'b1);
            tick();
        end
        reset = 1'b1;
        drive(1'b1, 5'd3, 2'd0, 1'b1, 3'd1, 32'h9, 1'b0, 1'b0);
        chk("midreset_we_a", 64'(rf_we_a), 64'(0));
        chk("midreset_we_b", 64'(rf_we_b), 64'(0));
        tick();
        reset = 1'b0;
        sbq.delete();
        exp_tail = 3'd0;
        idle();
        chk("midreset_count",        64'(dut.count),    64'(0));
        chk("midreset_alloc_tag",    64'(alloc_tag),    64'(0));
        chk("midreset_commit_tag",   64'(commit_tag),   64'(0));
        chk("midreset_commit_valid", 64'(commit_valid), 64'(0));
        chk("midreset_flush",        64'(flush),        64'(0));

        tick();
        chk("sb_drained",    64'(sbq.size()), 64'(0));
        chk("total_commits", 64'(n_commits),  64'(34));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob_controller.md
Name: rob_controller

Overview:
- Allocation/writeback/commit control for the 8-entry reorder buffer.
- Owns the head and tail pointers and the occupancy count.
- Drives write port a (allocate at tail) and write port b (writeback by tag) of rob_register_file; reads the head entry through its read port c.
- Presents in-order commit with a valid/ready handshake; flushes on a committed exception.

Parameters:
- NUM_ENTRIES, 8, ROB depth; power of two, matches rob_register_file.
- LOG_NUM_ENTRIES, 3, pointer/tag width.
- WIDTH, 41, entry width; layout is [40] done, [39] exc, [38:34] dest, [33:32] type, [31:0] value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  rename requests an entry
- alloc_dest  in  5  architectural destination
- alloc_type  in  2  instruction type
- alloc_ready  out  1  entry available (count != NUM_ENTRIES)
- alloc_tag  out  LOG_NUM_ENTRIES  tag granted (current tail)
- wb_valid  in  1  execution result valid
- wb_tag  in  LOG_NUM_ENTRIES  entry being completed
- wb_value  in  32  result
- wb_exc  in  1  result raised exception
- commit_valid  out  1  head entry done and ROB non-empty
- commit_ready  in  1  retire stage accepts
- commit_tag  out  LOG_NUM_ENTRIES  head pointer
- commit_dest  out  5  head dest
- commit_value  out  32  head value
- commit_exc  out  1  head exception flag
- flush  out  1  one-cycle pulse after an exception commits
- rf_wr_addr_a, rf_wr_data_a, rf_we_a  out  LOG/WIDTH/1  allocate write
- rf_wr_addr_b, rf_wr_data_b, rf_we_b  out  LOG/WIDTH/1  writeback write
- rf_rd_addr_c  out  LOG_NUM_ENTRIES  equals head
- rf_rd_data_c  in  WIDTH  head entry contents

Behaviour:
- Reset (synchronous, active-high):
  - head=0, tail=0, count=0, flush=0.
  - commit_valid=0, alloc_ready=1, alloc_tag=0.
  - All rf write enables are 0 in the reset cycle.
- Allocation (alloc_valid && alloc_ready):
  - rf_we_a=1, rf_wr_addr_a=tail.
  - rf_wr_data_a={1'b0,1'b0,alloc_dest,alloc_type,32'b0}.
  - tail<=tail+1, with natural wrap 7->0.
- Writeback (wb_valid && tag in flight):
  - rf_we_b=1, rf_wr_addr_b=wb_tag.
  - Data = {1'b1, wb_exc, dest/type taken from the stored entry, wb_value}.
  - Dest/type are supplied via a local shadow of the 7 dest/type bits, written at allocation.
  - "In flight" means (wb_tag-head) mod NUM_ENTRIES < count.
  - A writeback to a tag not in flight is ignored: rf_we_b=0.
- Commit:
  - commit_valid = (count!=0) && rf_rd_data_c[40].
  - Outputs are combinational from rf_rd_data_c.
  - On commit_valid && commit_ready: head<=head+1.
- Latency: a writeback is visible to commit no earlier than the next cycle (register write); allocate-to-commit minimum is 2 cycles.
- Count:
  - +1 on allocate, -1 on commit.
  - Unchanged when both happen in the same cycle.
  - Width LOG_NUM_ENTRIES+1.
- Full (count=8): alloc_ready=0. There is no same-cycle bypass of a concurrent commit.
- Empty (count=0): commit_valid=0 regardless of stale done bits.
- Exception commit (commit handshake with commit_exc=1):
  - Next cycle: head=tail=0, count=0, flush=1 for exactly one cycle.
  - Any allocate or writeback in the handshake cycle is suppressed: rf_we_a=0, rf_we_b=0, pointers not advanced.
- Reset mid-operation has priority over everything; state returns to reset values.

Optional Feature:
- Macro: ROB_STATS_EN.
- When defined, adds two outputs:
  - stat_commits [31:0]: increments on each commit handshake.
  - stat_full_stalls [31:0]: increments on each cycle with alloc_valid && !alloc_ready.
- Both counters reset to 0 and saturate at all-ones.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- rob_pkg: entry bit positions (DONE_BIT=40, EXC_BIT=39, DEST_MSB/LSB, TYPE_MSB/LSB, VALUE_MSB/LSB), NUM_ENTRIES, LOG_NUM_ENTRIES.
- Sub-module rob_ptr_counter: LOG-wide pointer with enable, synchronous clear and wrap.
  - Instantiated for head and tail.

Test Plan:
- Reset, then allocate 3 (dest 1,2,3) -> alloc_tag 0,1,2; count=3; commit_valid=0.
- Writeback tag1 value 0xAA, then tag0 value 0x55 -> commits in order: tag0/0x55/dest1, then tag1/0xAA/dest2; head=2.
- Allocate 8 with no commit -> alloc_ready=0 at count=8; a 9th alloc_valid has no rf_we_a; same-cycle alloc+commit at count=7 keeps count=7.
- Wrap: repeated alloc/commit for 20 entries -> tags wrap 7->0; value order preserved.
- Writeback to tag 5 when only tags 0-1 are in flight -> rf_we_b=0; no state change.
- Writeback tag0 with exc=1 while tags 1-3 are in flight, commit_ready=1 -> flush pulses 1 cycle; head=tail=count=0; a concurrent alloc is ignored.
